// File: rtl/mux_pipe_stage_if.sv
// mux_pipe_stage_if: handshake bundle for mux_pipe_stage.
//   Producer side: in_data (N_IN*WIDTH packed, input k at [k*WIDTH +: WIDTH]),
//                  in_sel, in_valid, in_ready, flush.
//   Consumer side: out_data, out_sel_err, out_valid, out_ready,
//                  out_parity (only when MUX_PIPE_STAGE_PARITY_EN is defined).
// Modports: master = the environment driving the stage, slave = the stage itself.
interface mux_pipe_stage_if #(
    parameter int WIDTH = 32,
    parameter int N_IN  = 4,
    parameter int SEL_W = $clog2(N_IN)
);
    logic [N_IN*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]      in_sel;
    logic                  in_valid;
    logic                  in_ready;
    logic                  flush;
    logic [WIDTH-1:0]      out_data;
    logic                  out_sel_err;
    logic                  out_valid;
    logic                  out_ready;
`ifdef MUX_PIPE_STAGE_PARITY_EN
    logic                  out_parity;

    modport master (
        output in_data, in_sel, in_valid, flush, out_ready,
        input  in_ready, out_data, out_sel_err, out_valid, out_parity
    );

    modport slave (
        input  in_data, in_sel, in_valid, flush, out_ready,
        output in_ready, out_data, out_sel_err, out_valid, out_parity
    );
`else
    modport master (
        output in_data, in_sel, in_valid, flush, out_ready,
        input  in_ready, out_data, out_sel_err, out_valid
    );

    modport slave (
        input  in_data, in_sel, in_valid, flush, out_ready,
        output in_ready, out_data, out_sel_err, out_valid
    );
`endif
endinterface

// File: rtl/mux_pipe_stage.sv
// mux_pipe_stage: N_IN-input, WIDTH-bit selector with a registered output and
// a valid/ready handshake. A main/skid entry pair gives full throughput with a
// registered in_ready and strict in-order delivery under back-pressure.
//
// Ports:
//   clk    - clock, rising edge
//   rst_n  - synchronous active-low reset
//   bus    - mux_pipe_stage_if.slave (in_data, in_sel, in_valid, in_ready, flush,
//            out_data, out_sel_err, out_valid, out_ready[, out_parity])
//
// Optional: define MUX_PIPE_STAGE_PARITY_EN to store and drive out_parity, the
// XOR reduction of the main entry's data.
//
// state | meaning
// ------+---------------------------------------------
// EMPTY | no entry held, out_valid=0
// ONE   | main entry valid, skid free
// FULL  | main and skid valid, in_ready=0
module mux_pipe_stage #(
    parameter int WIDTH = 32,
    parameter int N_IN  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    mux_pipe_stage_if.slave   bus
);
    localparam int SEL_W = $clog2(N_IN);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;

    logic [WIDTH-1:0] main_data_q;
    logic             main_err_q;
    logic [WIDTH-1:0] skid_data_q;
    logic             skid_err_q;

    logic [WIDTH-1:0] cap_data;
    logic             cap_err;

    logic             accept;
    logic             pop;
    logic             load_main_cap;
    logic             load_main_skid;
    logic             load_skid;

    // Out-of-range selects capture zero and flag an error.
    always_comb begin
        cap_data = '0;
        cap_err  = 1'b1;
        for (int k = 0; k < N_IN; k++) begin
            if (bus.in_sel == SEL_W'(k)) begin
                cap_data = bus.in_data[k*WIDTH +: WIDTH];
                cap_err  = 1'b0;
            end
        end
    end

    // in_ready depends only on registered state (and reset), never on out_ready.
    assign bus.in_ready  = rst_n && (state_q != FULL);
    assign bus.out_valid = (state_q != EMPTY);
    assign accept        = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        load_main_cap  = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (bus.flush) begin
            // Storage is left as-is; it is unobservable once out_valid drops.
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        load_main_cap = 1'b1;
                        state_d       = ONE;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        load_main_cap = 1'b1;
                    end else if (accept) begin
                        load_skid = 1'b1;
                        state_d   = FULL;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        load_main_skid = 1'b1;
                        state_d        = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_data_q <= '0;
            main_err_q  <= 1'b0;
            skid_data_q <= '0;
            skid_err_q  <= 1'b0;
        end else begin
            if (load_main_cap) begin
                main_data_q <= cap_data;
                main_err_q  <= cap_err;
            end else if (load_main_skid) begin
                main_data_q <= skid_data_q;
                main_err_q  <= skid_err_q;
            end
            if (load_skid) begin
                skid_data_q <= cap_data;
                skid_err_q  <= cap_err;
            end
        end
    end

    assign bus.out_data    = main_data_q;
    assign bus.out_sel_err = main_err_q;

`ifdef MUX_PIPE_STAGE_PARITY_EN
    logic main_par_q;
    logic skid_par_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_par_q <= 1'b0;
            skid_par_q <= 1'b0;
        end else begin
            if (load_main_cap) begin
                main_par_q <= ^cap_data;
            end else if (load_main_skid) begin
                main_par_q <= skid_par_q;
            end
            if (load_skid) begin
                skid_par_q <= ^cap_data;
            end
        end
    end

    assign bus.out_parity = main_par_q;
`endif

endmodule

// File: doc/mux_pipe_stage.md
Name: mux_pipe_stage

Overview:
- Parametrised N-input, WIDTH-bit selector with a registered output and a valid/ready handshake.
- Replaces the combinational 2:1 operand mux wherever a pipeline boundary is needed, e.g. writeback-select and forwarding-select stages.
- A 2-entry skid buffer gives full throughput, a registered-state in_ready, and strict in-order delivery under back-pressure.

Parameters:
- WIDTH, 32, data width per input.
- N_IN, 4, number of inputs (>= 2).
- SEL_W, $clog2(N_IN), select width (derived; not overridden).

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst_n  in  1  synchronous active-low reset.
- in_data  in  N_IN*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
- in_sel  in  SEL_W  input select.
- in_valid  in  1  producer offers in_data/in_sel.
- in_ready  out  1  stage can accept.
- flush  in  1  discard all buffered entries.
- out_data  out  WIDTH  selected word.
- out_sel_err  out  1  entry was captured with in_sel >= N_IN.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts.

Behaviour:
- Accept on a clock edge when in_valid && in_ready. Pop on a clock edge when out_valid && out_ready.
- Captured word: in_data[in_sel*WIDTH +: WIDTH] when in_sel < N_IN. Otherwise 0 with err=1. Select and capture happen in the same cycle.
- Storage: main entry {data, err}, which drives the outputs, plus skid entry {data, err}. State is EMPTY, ONE or FULL.
- in_ready = rst_n && (state != FULL); no combinational path from out_ready. out_valid = (state != EMPTY).
- EMPTY, accept: main <= captured; go to ONE. Latency is 1 cycle from accept to out_valid.
- ONE:
  - accept, no pop: skid <= captured; go to FULL.
  - pop, no accept: go to EMPTY.
  - accept and pop together: main <= captured; stay ONE.
- FULL, pop: main <= skid; go to ONE. No accept is possible because in_ready=0.
- Data order is always preserved; no entry is dropped or duplicated.
- Outputs hold stable while out_valid && !out_ready.
- flush (synchronous, highest priority after reset):
  - next state EMPTY; same-cycle accept and pop are ignored.
  - out_data, out_sel_err and skid contents are left unchanged but meaningless.
  - in_ready stays as computed from the current state.
- Reset (rst_n=0 at an edge, including mid-transfer):
  - state EMPTY; main and skid data = 0, err = 0.
  - out_valid=0, out_data=0, out_sel_err=0.
  - in_ready is 0 while rst_n is low and 1 in the first cycle after release.
- Sustained throughput is 1 word/cycle with in_valid and out_ready both held high.

Optional Feature:
- Macro: MUX_PIPE_STAGE_PARITY_EN.
- Defined:
  - Adds port out_parity (out, 1) = even parity (XOR reduce) of the main entry's data, stored alongside it.
  - Parity is computed at capture, moves to main together with the skid data, and resets to 0.
- Undefined: no out_parity port, no parity storage; all other behaviour is identical.

Test Plan:
- Reset: rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, out_data=0, in_ready=0; after release in_ready=1 and state EMPTY.
- Basic select: N_IN=4, in_data words {10,20,30,40}, in_sel=2, in_valid 1 cycle, out_ready=1 -> next cycle out_valid=1, out_data=30, out_sel_err=0.
- Back-pressure: out_ready=0, push 10 then 20 -> in_ready=0 after the 2nd accept. Raise out_ready -> outputs 10 then 20 on consecutive cycles; in_ready returns to 1 after the first pop.
- Streaming: in_valid=out_ready=1, in_sel cycling 0,1,2,3 over words {1,2,3,4} for 8 cycles -> output 1,2,3,4,1,2,3,4 each one cycle after accept; in_ready never drops.
- Bad select: N_IN=3, in_sel=3, word data 0xFFFF_FFFF -> out_data=0, out_sel_err=1.
- Flush: FULL state, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed words never appear. With MUX_PIPE_STAGE_PARITY_EN, a capture of 0x0000_0007 gives out_parity=1.
